// File: rtl/button_conditioner_pkg.sv
// Shared types for the push-button front-end: button indices, arbitration order,
// debouncer states and the fixed-priority grant helper.
package button_pkg;

  localparam int N_BTN = 5;

  typedef enum logic [2:0] {
    BTN_LEFT   = 3'd0,
    BTN_RIGHT  = 3'd1,
    BTN_UP     = 3'd2,
    BTN_DOWN   = 3'd3,
    BTN_SELECT = 3'd4
  } btn_idx_e;

  // Highest priority first.
  localparam btn_idx_e PRIO_ORDER [N_BTN] = '{BTN_SELECT, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } deb_state_e;

  function automatic logic [N_BTN-1:0] priorityGrant(input logic [N_BTN-1:0] req);
    logic [N_BTN-1:0] grant;
    grant = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (grant == '0 && req[PRIO_ORDER[i]]) grant[PRIO_ORDER[i]] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw pins / game FSM side (master) and the conditioner (slave).
interface button_conditioner_if;

  logic [button_pkg::N_BTN-1:0] btn_raw;
  logic [button_pkg::N_BTN-1:0] btn_level;
  logic                         btnLeft;
  logic                         btnRight;
  logic                         btnUp;
  logic                         btnDown;
  logic                         btnSelect;

  modport master (
    output btn_raw,
    input  btn_level, btnLeft, btnRight, btnUp, btnDown, btnSelect
  );

  modport slave (
    input  btn_raw,
    output btn_level, btnLeft, btnRight, btnUp, btnDown, btnSelect
  );

endinterface

// File: rtl/button_debouncer.sv
// One button: flop synchroniser, agreement counter and debounce FSM producing a
// stable level plus a one-cycle strobe registered together with each level rise.
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   synced;
  deb_state_e             state, stateNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic                   differ, done, levelNext;

  assign synced = syncQ[SYNC_STAGES-1];

  always_comb begin
    stateNext = state;
    differ    = synced ^ level;
    done      = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    cntNext   = (differ && !done) ? cnt + CNT_W'(1) : '0;
    case (state)
      IDLE:         if (synced) stateNext = done ? PRESSED : WAIT_PRESS;
      WAIT_PRESS:   if (!synced) stateNext = IDLE;
                    else if (done) stateNext = PRESSED;
      PRESSED:      if (!synced) stateNext = done ? IDLE : WAIT_RELEASE;
      WAIT_RELEASE: if (synced) stateNext = PRESSED;
                    else if (done) stateNext = IDLE;
      default:      stateNext = IDLE;
    endcase
    levelNext = (stateNext == PRESSED) || (stateNext == WAIT_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncQ <= '0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], raw};
      state <= stateNext;
      cnt   <= cntNext;
      level <= levelNext;
      rise  <= levelNext & ~level;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five-button front-end: debounced levels, pending-press register and fixed-priority
// one-hot pulse arbiter. Define BTN_AUTOREPEAT_EN to enable direction auto-repeat.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParam
    $error("button_conditioner: parameter out of range");
  end

  logic [N_BTN-1:0] levelP0, riseP0, repTick, setReq, req, grant;
  logic [N_BTN-1:0] pendP0, pulseP1;

  for (genvar b = 0; b < N_BTN; b++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[b]),
      .level(levelP0[b]),
      .rise (riseP0[b])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  for (genvar b = 0; b < N_BTN; b++) begin : g_rep
    if (b == int'(BTN_SELECT)) begin : g_noRep
      assign repTick[b] = 1'b0;
    end else begin : g_hold
      logic [HOLD_W-1:0] holdCnt;
      logic              repeating;
      logic              hit;

      // Count restarts at 1 after each hit so the next hit lands REPEAT_PERIOD later.
      assign hit = levelP0[b] &&
                   (holdCnt == (repeating ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY)));
      assign repTick[b] = hit;

      always_ff @(posedge clk) begin
        if (!rst || !levelP0[b]) begin
          holdCnt   <= '0;
          repeating <= 1'b0;
        end else if (hit) begin
          holdCnt   <= HOLD_W'(1);
          repeating <= 1'b1;
        end else begin
          holdCnt   <= holdCnt + HOLD_W'(1);
        end
      end
    end
  end
`else
  assign repTick = '0;
`endif

  // Stage p0: pending requests merged with new strobes, one granted per cycle.
  always_comb begin
    setReq = riseP0 | repTick;
    req    = pendP0 | setReq;
    grant  = priorityGrant(req);
  end

  // A fresh strobe on a bit being granted from pending is a new press and survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pendP0  <= '0;
      pulseP1 <= '0;
    end else begin
      pendP0  <= (req & ~grant) | (setReq & pendP0 & grant);
      pulseP1 <= grant;
    end
  end

  // Stage p1: registered one-hot-or-zero pulses.
  assign bus.btn_level = levelP0;
  assign bus.btnLeft   = pulseP1[BTN_LEFT];
  assign bus.btnRight  = pulseP1[BTN_RIGHT];
  assign bus.btnUp     = pulseP1[BTN_UP];
  assign bus.btnDown   = pulseP1[BTN_DOWN];
  assign bus.btnSelect = pulseP1[BTN_SELECT];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: cycle-exact vector table plus hand sequences
// for bounce, reset mid-count and (build-dependent) auto-repeat.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int RD  = 8;
  localparam int RP  = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [4:0] pulseVec;
  assign pulseVec = {bus.btnSelect, bus.btnDown, bus.btnUp, bus.btnRight, bus.btnLeft};

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic       rstV;
    logic [4:0] raw;
    logic [4:0] expLevel;
    logic [4:0] expPulse;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void addRun(input logic r, input logic [4:0] raw, input int n,
                                 input logic [4:0] lvl, input logic [4:0] pls, input string tag);
    vec_t v;
    v.rstV = r; v.raw = raw; v.expLevel = lvl; v.expPulse = pls; v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic edgeStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    bus.btn_raw = 5'h00;
    edgeStep();
    rst = 1'b1;
  endtask

  int edgesR[$];
  int edgesS[$];
  int expR[$];
  int cnt, at, other;

  initial begin
    bus.btn_raw = 5'h00;

    // Test 1: reset with all pins high, then priority drain Select, Up, Down, Left, Right.
    addRun(1'b0, 5'h1F, 2, 5'h00, 5'h00, "t1_reset");
    addRun(1'b1, 5'h1F, 5, 5'h00, 5'h00, "t1_wait");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h00, "t1_level");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h10, "t1_select");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h04, "t1_up");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h08, "t1_down");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h01, "t1_left");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h02, "t1_right");
    addRun(1'b1, 5'h1F, 1, 5'h1F, 5'h00, "t1_drained");
    addRun(1'b0, 5'h00, 1, 5'h00, 5'h00, "t1_reset2");
    // Test 2: single Down press held 12 cycles, then released.
    addRun(1'b1, 5'h08, 5, 5'h00, 5'h00, "t2_wait");
    addRun(1'b1, 5'h08, 1, 5'h08, 5'h00, "t2_level");
    addRun(1'b1, 5'h08, 1, 5'h08, 5'h08, "t2_pulse");
    addRun(1'b1, 5'h08, 5, 5'h08, 5'h00, "t2_hold");
    addRun(1'b1, 5'h00, 2, 5'h08, 5'h00, "t2_rel");
    addRun(1'b1, 5'h00, 1, 5'h08, AR ? 5'h08 : 5'h00, "t2_rel_rep1");
    addRun(1'b1, 5'h00, 2, 5'h08, 5'h00, "t2_rel2");
    addRun(1'b1, 5'h00, 1, 5'h00, AR ? 5'h08 : 5'h00, "t2_fall");
    addRun(1'b1, 5'h00, 2, 5'h00, 5'h00, "t2_idle");
    // Test 4: Up and Left together.
    addRun(1'b1, 5'h05, 5, 5'h00, 5'h00, "t4_wait");
    addRun(1'b1, 5'h05, 1, 5'h05, 5'h00, "t4_level");
    addRun(1'b1, 5'h05, 1, 5'h05, 5'h04, "t4_up");
    addRun(1'b1, 5'h05, 1, 5'h05, 5'h01, "t4_left");
    addRun(1'b1, 5'h00, 5, 5'h05, 5'h00, "t4_rel");
    addRun(1'b1, 5'h00, 2, 5'h00, 5'h00, "t4_fall");

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rstV;
      bus.btn_raw = vecs[i].raw;
      edgeStep();
      check({vecs[i].tag, "_level"}, 32'(bus.btn_level), 32'(vecs[i].expLevel));
      check({vecs[i].tag, "_pulse"}, 32'(pulseVec), 32'(vecs[i].expPulse));
      check({vecs[i].tag, "_onehot"}, 32'($countones(pulseVec) <= 1), 32'd1);
    end

    // Test 3: bouncing Right for 8 cycles, then steady high.
    doReset();
    other = 0;
    for (int i = 0; i < 8; i++) begin
      bus.btn_raw = (i % 2 == 0) ? 5'h02 : 5'h00;
      edgeStep();
      if (pulseVec != 5'h00 || bus.btn_level != 5'h00) other++;
    end
    check("t3_bounce_quiet", 32'(other), 32'd0);
    bus.btn_raw = 5'h02;
    cnt = 0; at = -1; other = 0;
    for (int k = 1; k <= 12; k++) begin
      edgeStep();
      if (bus.btnRight) begin cnt++; at = k; end
      if ((pulseVec & 5'h1D) != 5'h00) other++;
    end
    check("t3_right_count", 32'(cnt), 32'd1);
    check("t3_right_edge", 32'(at), 32'd7);
    check("t3_others", 32'(other), 32'd0);

    // Test 5: reset discards a press in progress.
    doReset();
    bus.btn_raw = 5'h01;
    other = 0;
    for (int i = 0; i < 3; i++) begin
      edgeStep();
      if (pulseVec != 5'h00) other++;
    end
    check("t5_pre_reset_pulses", 32'(other), 32'd0);
    rst = 1'b0;
    edgeStep();
    check("t5_in_reset_level", 32'(bus.btn_level), 32'd0);
    check("t5_in_reset_pulse", 32'(pulseVec), 32'd0);
    rst = 1'b1;
    cnt = 0; at = -1;
    for (int k = 1; k <= 12; k++) begin
      edgeStep();
      if (bus.btnLeft) begin cnt++; at = k; end
    end
    check("t5_left_count", 32'(cnt), 32'd1);
    check("t5_left_edge", 32'(at), 32'd7);

    // Test 6: Right held well past its level rise; repeats only in the auto-repeat build.
    doReset();
    bus.btn_raw = 5'h02;
    for (int k = 1; k <= 40; k++) begin
      if (k == 26) bus.btn_raw = 5'h00;
      edgeStep();
      if (bus.btnRight) edgesR.push_back(k);
    end
    expR.push_back(7);
    if (AR) begin
      expR.push_back(15); expR.push_back(18); expR.push_back(21);
      expR.push_back(24); expR.push_back(27); expR.push_back(30);
    end
    check("t6_right_count", 32'(edgesR.size()), 32'(expR.size()));
    for (int i = 0; i < expR.size() && i < edgesR.size(); i++)
      check($sformatf("t6_right_edge%0d", i), 32'(edgesR[i]), 32'(expR[i]));

    // Select held: never repeats.
    doReset();
    bus.btn_raw = 5'h10;
    for (int k = 1; k <= 40; k++) begin
      edgeStep();
      if (bus.btnSelect) edgesS.push_back(k);
    end
    check("t6_select_count", 32'(edgesS.size()), 32'd1);
    if (edgesS.size() > 0) check("t6_select_edge", 32'(edgesS[0]), 32'd7);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
